friscv_regfile_sb: RTL and testbench
====================================

FRISCV_REGFILE_SB -- requirements
Module: friscv_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 SHALL have parameter NB_REG, default 32, number of ISA registers; legal values 16 (RV32E) or 32.
REQ-003 SHALL have parameter NB_CH, default 2, number of independent read/write channels; legal range 1..4.
REQ-004 SHALL have port aclk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports rs1_addr, rs2_addr  input  NB_CH*5  per-channel read addresses, channel c at bits [5c+4:5c].
REQ-007 SHALL have ports rs1_val, rs2_val  output  NB_CH*XLEN  per-channel read data, combinational.
REQ-008 SHALL have ports rs1_busy, rs2_busy  output  NB_CH  per-channel pending-write flag of addressed register.
REQ-009 SHALL have ports rd_wr  input  NB_CH; rd_addr  input  NB_CH*5; rd_val  input  NB_CH*XLEN  per-channel write port.
REQ-010 SHALL have ports sb_claim  input  1; sb_claim_addr  input  5  mark one register as pending a future write.
REQ-011 SHALL have ports sb_release  input  1; sb_release_addr  input  5  retire one pending write.
REQ-012 SHALL have port rf_err  output  1  registered one-cycle error pulse.
REQ-013 SHALL have port regs  output  NB_REG*XLEN  flattened register contents, register n at [XLEN*n+XLEN-1:XLEN*n].

Function
REQ-014 Register x0 SHALL always read 0; writes, claims and releases to x0 SHALL be ignored without error; busy for x0 SHALL be 0.
REQ-015 Write with rd_wr[c]=1 SHALL update the register on the next rising edge (1-cycle latency).
REQ-016 When several channels write the same address in one cycle, the highest channel index SHALL win; no error raised.
REQ-017 Address >= NB_REG on read SHALL return 0 and busy 0; on write, claim or release SHALL be ignored and raise rf_err next cycle.
REQ-018 Each register SHALL hold a 2-bit pending counter; busy = counter != 0.
REQ-019 sb_claim SHALL increment the counter of sb_claim_addr; claim at count 3 SHALL be dropped and raise rf_err.
REQ-020 sb_release SHALL decrement the counter of sb_release_addr; release at count 0 SHALL be dropped and raise rf_err.
REQ-021 Claim and release of the same register in one cycle SHALL leave the counter unchanged, no error, even at 0 or 3.
REQ-022 Writes SHALL NOT modify pending counters; scoreboard state and data state are independent.
REQ-023 Busy outputs SHALL reflect counter state before the current edge (no same-cycle forwarding of claim/release).
REQ-024 rf_err SHALL be high for exactly one cycle per offending cycle, OR of all error sources.

Reset
REQ-025 With aresetn=0 at a rising edge, all registers SHALL become 0, all pending counters 0, rf_err 0.
REQ-026 Reset mid-operation SHALL discard all same-cycle writes, claims and releases.
REQ-027 Without reset, state SHALL be unchanged except by REQ-015..REQ-021.

Configuration
REQ-028 Macro FRISCV_RF_BYPASS_EN defined: a read whose address matches a same-cycle write (winner per REQ-016) SHALL return rd_val combinationally.
REQ-029 Macro FRISCV_RF_BYPASS_EN undefined: reads SHALL return the stored value; new data visible the cycle after the write.

Verification
REQ-030 Reset then write x5=0xDEADBEEF on ch0 -> rs1_val ch1 addr 5 reads 0xDEADBEEF next cycle; same cycle reads 0 (bypass off) or 0xDEADBEEF (bypass on).
REQ-031 ch0 and ch1 write x7 with 0x1 and 0x2 same cycle -> x7=0x2, rf_err=0.
REQ-032 Write x0=0xFFFFFFFF, claim x0 -> x0 reads 0, busy 0, rf_err=0.
REQ-033 Claim x3 four times -> busy=1, counter 3, rf_err pulses once on 4th; three releases -> busy=0; 4th release -> rf_err pulse.
REQ-034 NB_REG=16, write x20 -> regs unchanged, rf_err=1 for one cycle; read x20 -> 0.
REQ-035 Claim x9 twice, then aresetn=0 with simultaneous write x9 -> after edge x9=0, busy 0, rf_err 0.

Source files
------------

// File: rtl/friscv_regfile_sb.sv
// Multi-channel RISC-V integer register file with a per-register 2-bit pending-write scoreboard.
// Define FRISCV_RF_BYPASS_EN to forward same-cycle write data onto the read ports.
module friscv_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NB_REG = 32,
    parameter int NB_CH  = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NB_CH*5-1:0]      rs1_addr,
    input  logic [NB_CH*5-1:0]      rs2_addr,
    output logic [NB_CH*XLEN-1:0]   rs1_val,
    output logic [NB_CH*XLEN-1:0]   rs2_val,
    output logic [NB_CH-1:0]        rs1_busy,
    output logic [NB_CH-1:0]        rs2_busy,
    input  logic [NB_CH-1:0]        rd_wr,
    input  logic [NB_CH*5-1:0]      rd_addr,
    input  logic [NB_CH*XLEN-1:0]   rd_val,
    input  logic                    sb_claim,
    input  logic [4:0]              sb_claim_addr,
    input  logic                    sb_release,
    input  logic [4:0]              sb_release_addr,
    output logic                    rf_err,
    output logic [NB_REG*XLEN-1:0]  regs
);

    localparam int AW = $clog2(NB_REG);

    logic [XLEN-1:0] regs_q [NB_REG];
    logic [XLEN-1:0] regs_d [NB_REG];
    logic [1:0]      cnt_q  [NB_REG];
    logic [1:0]      cnt_d  [NB_REG];
    logic            err_q;
    logic            err_d;
    logic            err_wr;
    logic            err_sb;
    logic            claim_ok;
    logic            rel_ok;

    function automatic logic in_range(input logic [4:0] a);
        return 32'(a) < 32'(NB_REG);
    endfunction

    function automatic logic [AW-1:0] idx(input logic [4:0] a);
        return a[AW-1:0];
    endfunction

    // x0 and out-of-range addresses read as zero and are never busy
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (in_range(a) && a != 5'd0) begin
            v = regs_q[idx(a)];
`ifdef FRISCV_RF_BYPASS_EN
            for (int c = 0; c < NB_CH; c++) begin
                if (rd_wr[c] && rd_addr[5*c +: 5] == a)
                    v = rd_val[XLEN*c +: XLEN];
            end
`endif
        end
        return v;
    endfunction

    function automatic logic busy_port(input logic [4:0] a);
        return in_range(a) && a != 5'd0 && cnt_q[idx(a)] != 2'd0;
    endfunction

    // Ascending channel order lets the highest channel win on address collisions
    always_comb begin
        regs_d = regs_q;
        err_wr = 1'b0;
        for (int c = 0; c < NB_CH; c++) begin
            if (rd_wr[c]) begin
                if (!in_range(rd_addr[5*c +: 5]))
                    err_wr = 1'b1;
                else if (rd_addr[5*c +: 5] != 5'd0)
                    regs_d[idx(rd_addr[5*c +: 5])] = rd_val[XLEN*c +: XLEN];
            end
        end
    end

    assign claim_ok = sb_claim && sb_claim_addr != 5'd0 && in_range(sb_claim_addr);
    assign rel_ok   = sb_release && sb_release_addr != 5'd0 && in_range(sb_release_addr);

    // A claim and release hitting the same register cancel out, even at saturation
    always_comb begin
        cnt_d  = cnt_q;
        err_sb = (sb_claim && !in_range(sb_claim_addr)) ||
                 (sb_release && !in_range(sb_release_addr));
        if (!(claim_ok && rel_ok && sb_claim_addr == sb_release_addr)) begin
            if (claim_ok) begin
                if (cnt_q[idx(sb_claim_addr)] == 2'd3)
                    err_sb = 1'b1;
                else
                    cnt_d[idx(sb_claim_addr)] = cnt_q[idx(sb_claim_addr)] + 2'd1;
            end
            if (rel_ok) begin
                if (cnt_q[idx(sb_release_addr)] == 2'd0)
                    err_sb = 1'b1;
                else
                    cnt_d[idx(sb_release_addr)] = cnt_q[idx(sb_release_addr)] - 2'd1;
            end
        end
    end

    assign err_d = err_wr | err_sb;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int n = 0; n < NB_REG; n++) begin
                regs_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign rf_err = err_q;

    for (genvar ch = 0; ch < NB_CH; ch++) begin : g_rd
        assign rs1_val[XLEN*ch +: XLEN] = read_port(rs1_addr[5*ch +: 5]);
        assign rs2_val[XLEN*ch +: XLEN] = read_port(rs2_addr[5*ch +: 5]);
        assign rs1_busy[ch]             = busy_port(rs1_addr[5*ch +: 5]);
        assign rs2_busy[ch]             = busy_port(rs2_addr[5*ch +: 5]);
    end

    for (genvar n = 0; n < NB_REG; n++) begin : g_regs
        assign regs[XLEN*n +: XLEN] = regs_q[n];
    end

endmodule

// File: tb/tb_friscv_regfile_sb.sv
// Bench for friscv_regfile_sb: a 32-register and a 16-register instance share stimulus,
// each tracked by its own reference model. Honours FRISCV_RF_BYPASS_EN when defined.
module tb_friscv_regfile_sb;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [9:0]   rs1_addr, rs2_addr, rd_addr;
    logic [63:0]  rs1_val, rs2_val, rs1_val16, rs2_val16, rd_val;
    logic [1:0]   rs1_busy, rs2_busy, rs1_busy16, rs2_busy16, rd_wr;
    logic         sb_claim, sb_release, rf_err, rf_err16;
    logic [4:0]   sb_claim_addr, sb_release_addr;
    logic [1023:0] regs;
    logic [511:0]  regs16;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_regs [2][32];
    logic [1:0]  m_cnt  [2][32];
    logic        m_err  [2];

    always #5 aclk = ~aclk;

    friscv_regfile_sb #(.XLEN(32), .NB_REG(32), .NB_CH(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd_wr(rd_wr), .rd_addr(rd_addr), .rd_val(rd_val),
        .sb_claim(sb_claim), .sb_claim_addr(sb_claim_addr),
        .sb_release(sb_release), .sb_release_addr(sb_release_addr),
        .rf_err(rf_err), .regs(regs)
    );

    friscv_regfile_sb #(.XLEN(32), .NB_REG(16), .NB_CH(2)) dut16 (
        .aclk(aclk), .aresetn(aresetn),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val16), .rs2_val(rs2_val16),
        .rs1_busy(rs1_busy16), .rs2_busy(rs2_busy16),
        .rd_wr(rd_wr), .rd_addr(rd_addr), .rd_val(rd_val),
        .sb_claim(sb_claim), .sb_claim_addr(sb_claim_addr),
        .sb_release(sb_release), .sb_release_addr(sb_release_addr),
        .rf_err(rf_err16), .regs(regs16)
    );

    function automatic int nbr(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] mread(input int k, input logic [4:0] a);
        int ai;
        logic [31:0] v;
        ai = int'(a);
        v  = '0;
        if (ai != 0 && ai < nbr(k)) begin
            v = m_regs[k][ai];
`ifdef FRISCV_RF_BYPASS_EN
            for (int c = 0; c < 2; c++)
                if (rd_wr[c] && rd_addr[5*c +: 5] == a) v = rd_val[32*c +: 32];
`endif
        end
        return v;
    endfunction

    function automatic logic mbusy(input int k, input logic [4:0] a);
        int ai;
        ai = int'(a);
        return ai != 0 && ai < nbr(k) && m_cnt[k][ai] != 2'd0;
    endfunction

    function automatic logic [63:0] exp_rd(input int k, input logic [9:0] a);
        return {mread(k, a[9:5]), mread(k, a[4:0])};
    endfunction

    function automatic logic [1:0] exp_busy(input int k, input logic [9:0] a);
        return {mbusy(k, a[9:5]), mbusy(k, a[4:0])};
    endfunction

    function automatic logic [1023:0] exp_regs(input int k);
        logic [1023:0] v;
        v = '0;
        for (int n = 0; n < nbr(k); n++) v[32*n +: 32] = m_regs[k][n];
        return v;
    endfunction

    // Reference behaviour at one rising edge, from the architectural rules
    task automatic model_step();
        int  nb, a, ca, ra;
        logic e, cv, rv;
        for (int k = 0; k < 2; k++) begin
            nb = nbr(k);
            if (!aresetn) begin
                for (int n = 0; n < 32; n++) begin
                    m_regs[k][n] = '0;
                    m_cnt[k][n]  = '0;
                end
                m_err[k] = 1'b0;
            end else begin
                e = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    a = int'(rd_addr[5*c +: 5]);
                    if (rd_wr[c]) begin
                        if (a >= nb) e = 1'b1;
                        else if (a != 0) m_regs[k][a] = rd_val[32*c +: 32];
                    end
                end
                ca = int'(sb_claim_addr);
                ra = int'(sb_release_addr);
                if (sb_claim && ca >= nb) e = 1'b1;
                if (sb_release && ra >= nb) e = 1'b1;
                cv = sb_claim && ca != 0 && ca < nb;
                rv = sb_release && ra != 0 && ra < nb;
                if (!(cv && rv && ca == ra)) begin
                    if (cv) begin
                        if (m_cnt[k][ca] == 2'd3) e = 1'b1;
                        else m_cnt[k][ca] = m_cnt[k][ca] + 2'd1;
                    end
                    if (rv) begin
                        if (m_cnt[k][ra] == 2'd0) e = 1'b1;
                        else m_cnt[k][ra] = m_cnt[k][ra] - 2'd1;
                    end
                end
                m_err[k] = e;
            end
        end
    endtask

    task automatic idle();
        aresetn = 1'b1; rd_wr = '0; rd_addr = '0; rd_val = '0;
        rs1_addr = '0; rs2_addr = '0;
        sb_claim = 1'b0; sb_claim_addr = '0; sb_release = 1'b0; sb_release_addr = '0;
    endtask

    task automatic cycle();
        @(posedge aclk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        idle();
        aresetn = 1'b0;
        rd_wr = 2'b11; rd_addr = {5'd4, 5'd2}; rd_val = 64'h1111_2222_3333_4444;
        sb_claim = 1'b1; sb_claim_addr = 5'd2;
        cycle();
        idle();
        rs1_addr = {5'd4, 5'd2};
        #1;
        n_checks++; if (regs !== '0) $display("FAIL reset_regs got nonzero x1=%h x2=%h exp 0", regs[63:32], regs[95:64]); else n_pass++;
        n_checks++; if (regs16 !== '0) $display("FAIL reset_regs16 got nonzero exp 0"); else n_pass++;
        n_checks++; if (rf_err !== 1'b0) $display("FAIL reset_err got %b exp 0", rf_err); else n_pass++;
        n_checks++; if (rs1_busy !== 2'b00) $display("FAIL reset_busy got %b exp 00", rs1_busy); else n_pass++;
    endtask

    task automatic test_write_latency();
        logic [31:0] exp_same;
`ifdef FRISCV_RF_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        idle();
        rd_wr = 2'b01; rd_addr[4:0] = 5'd5; rd_val[31:0] = 32'hDEADBEEF;
        rs1_addr[9:5] = 5'd5;
        #1;
        n_checks++; if (rs1_val[63:32] !== exp_same) $display("FAIL wr_same_cycle got %h exp %h", rs1_val[63:32], exp_same); else n_pass++;
        cycle();
        idle();
        rs1_addr[9:5] = 5'd5;
        #1;
        n_checks++; if (rs1_val[63:32] !== 32'hDEADBEEF) $display("FAIL wr_next_cycle got %h exp deadbeef", rs1_val[63:32]); else n_pass++;
    endtask

    task automatic test_same_addr();
        idle();
        rd_wr = 2'b11; rd_addr = {5'd7, 5'd7}; rd_val = {32'h2, 32'h1};
        cycle();
        idle();
        n_checks++; if (regs[7*32 +: 32] !== 32'h2) $display("FAIL collide_x7 got %h exp 2", regs[7*32 +: 32]); else n_pass++;
        n_checks++; if (rf_err !== 1'b0) $display("FAIL collide_err got %b exp 0", rf_err); else n_pass++;
    endtask

    task automatic test_x0();
        idle();
        rd_wr = 2'b01; rd_addr[4:0] = 5'd0; rd_val[31:0] = 32'hFFFFFFFF;
        sb_claim = 1'b1; sb_claim_addr = 5'd0;
        cycle();
        idle();
        #1;
        n_checks++; if (rs1_val[31:0] !== 32'h0) $display("FAIL x0_read got %h exp 0", rs1_val[31:0]); else n_pass++;
        n_checks++; if (regs[31:0] !== 32'h0) $display("FAIL x0_regs got %h exp 0", regs[31:0]); else n_pass++;
        n_checks++; if (rs1_busy[0] !== 1'b0) $display("FAIL x0_busy got %b exp 0", rs1_busy[0]); else n_pass++;
        n_checks++; if (rf_err !== 1'b0) $display("FAIL x0_err got %b exp 0", rf_err); else n_pass++;
    endtask

    task automatic test_claim_sat();
        for (int i = 0; i < 4; i++) begin
            idle();
            sb_claim = 1'b1; sb_claim_addr = 5'd3;
            cycle();
            idle();
            rs1_addr[4:0] = 5'd3;
            #1;
            n_checks++; if (rf_err !== (i == 3)) $display("FAIL claim%0d_err got %b exp %b", i, rf_err, (i == 3)); else n_pass++;
            n_checks++; if (rs1_busy[0] !== 1'b1) $display("FAIL claim%0d_busy got %b exp 1", i, rs1_busy[0]); else n_pass++;
        end
        cycle();
        n_checks++; if (rf_err !== 1'b0) $display("FAIL claim_err_pulse got %b exp 0", rf_err); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            idle();
            sb_release = 1'b1; sb_release_addr = 5'd3;
            cycle();
            idle();
            rs1_addr[4:0] = 5'd3;
            #1;
            n_checks++; if (rf_err !== (i == 3)) $display("FAIL release%0d_err got %b exp %b", i, rf_err, (i == 3)); else n_pass++;
            n_checks++; if (rs1_busy[0] !== (i < 2)) $display("FAIL release%0d_busy got %b exp %b", i, rs1_busy[0], (i < 2)); else n_pass++;
        end
        idle();
        sb_claim = 1'b1; sb_claim_addr = 5'd3; sb_release = 1'b1; sb_release_addr = 5'd3;
        cycle();
        idle();
        rs1_addr[4:0] = 5'd3;
        #1;
        n_checks++; if (rf_err !== 1'b0) $display("FAIL claim_rel_cancel_err got %b exp 0", rf_err); else n_pass++;
        n_checks++; if (rs1_busy[0] !== 1'b0) $display("FAIL claim_rel_cancel_busy got %b exp 0", rs1_busy[0]); else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [1023:0] er;
        idle();
        rd_wr = 2'b01; rd_addr[4:0] = 5'd20; rd_val[31:0] = 32'h12345678;
        cycle();
        idle();
        rs1_addr[4:0] = 5'd20;
        #1;
        er = exp_regs(1);
        n_checks++; if (regs16 !== er[511:0]) $display("FAIL oor_regs16 changed exp unchanged"); else n_pass++;
        n_checks++; if (rf_err16 !== 1'b1) $display("FAIL oor_wr_err got %b exp 1", rf_err16); else n_pass++;
        n_checks++; if (rs1_val16[31:0] !== 32'h0) $display("FAIL oor_read got %h exp 0", rs1_val16[31:0]); else n_pass++;
        n_checks++; if (rs1_busy16[0] !== 1'b0) $display("FAIL oor_busy got %b exp 0", rs1_busy16[0]); else n_pass++;
        n_checks++; if (regs[20*32 +: 32] !== 32'h12345678) $display("FAIL x20_in_32 got %h exp 12345678", regs[20*32 +: 32]); else n_pass++;
        cycle();
        n_checks++; if (rf_err16 !== 1'b0) $display("FAIL oor_err_pulse got %b exp 0", rf_err16); else n_pass++;
        sb_release = 1'b1; sb_release_addr = 5'd25;
        cycle();
        idle();
        n_checks++; if (rf_err16 !== 1'b1) $display("FAIL oor_release_err got %b exp 1", rf_err16); else n_pass++;
        n_checks++; if (rf_err !== 1'b1) $display("FAIL release_at_zero_err got %b exp 1", rf_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle();
        rd_wr = 2'b10; rd_addr[9:5] = 5'd9; rd_val[63:32] = 32'h55;
        sb_claim = 1'b1; sb_claim_addr = 5'd9;
        cycle();
        idle();
        sb_claim = 1'b1; sb_claim_addr = 5'd9;
        cycle();
        idle();
        rs1_addr[4:0] = 5'd9;
        #1;
        n_checks++; if (rs1_busy[0] !== 1'b1) $display("FAIL pre_rst_busy got %b exp 1", rs1_busy[0]); else n_pass++;
        n_checks++; if (rs1_val[31:0] !== 32'h55) $display("FAIL pre_rst_x9 got %h exp 55", rs1_val[31:0]); else n_pass++;
        aresetn = 1'b0;
        rd_wr = 2'b01; rd_addr[4:0] = 5'd9; rd_val[31:0] = 32'hAAAA5555;
        sb_claim = 1'b1; sb_claim_addr = 5'd9;
        cycle();
        idle();
        rs1_addr[4:0] = 5'd9;
        #1;
        n_checks++; if (rs1_val[31:0] !== 32'h0) $display("FAIL rst_mid_x9 got %h exp 0", rs1_val[31:0]); else n_pass++;
        n_checks++; if (rs1_busy[0] !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", rs1_busy[0]); else n_pass++;
        n_checks++; if (rf_err !== 1'b0) $display("FAIL rst_mid_err got %b exp 0", rf_err); else n_pass++;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
    endfunction

    task automatic test_random();
        logic [63:0]   g64;
        logic [1:0]    g2;
        logic [1023:0] gr, er;
        logic          ge;
        for (int it = 0; it < 400; it++) begin
            aresetn         = ($urandom_range(0, 59) != 0);
            rd_wr           = 2'($urandom);
            rd_addr         = {rnd_addr(), rnd_addr()};
            rd_val          = {$urandom, $urandom};
            rs1_addr        = {rnd_addr(), rnd_addr()};
            rs2_addr        = {rnd_addr(), rnd_addr()};
            sb_claim        = 1'($urandom);
            sb_claim_addr   = rnd_addr();
            sb_release      = 1'($urandom);
            sb_release_addr = rnd_addr();
            #1;
            for (int k = 0; k < 2; k++) begin
                g64 = (k == 0) ? rs1_val : rs1_val16;
                n_checks++; if (g64 !== exp_rd(k, rs1_addr)) $display("FAIL rnd_rs1_val dut%0d it%0d got %h exp %h", k, it, g64, exp_rd(k, rs1_addr)); else n_pass++;
                g64 = (k == 0) ? rs2_val : rs2_val16;
                n_checks++; if (g64 !== exp_rd(k, rs2_addr)) $display("FAIL rnd_rs2_val dut%0d it%0d got %h exp %h", k, it, g64, exp_rd(k, rs2_addr)); else n_pass++;
                g2 = (k == 0) ? rs1_busy : rs1_busy16;
                n_checks++; if (g2 !== exp_busy(k, rs1_addr)) $display("FAIL rnd_rs1_busy dut%0d it%0d got %b exp %b", k, it, g2, exp_busy(k, rs1_addr)); else n_pass++;
                g2 = (k == 0) ? rs2_busy : rs2_busy16;
                n_checks++; if (g2 !== exp_busy(k, rs2_addr)) $display("FAIL rnd_rs2_busy dut%0d it%0d got %b exp %b", k, it, g2, exp_busy(k, rs2_addr)); else n_pass++;
            end
            cycle();
            for (int k = 0; k < 2; k++) begin
                gr = (k == 0) ? regs : {512'b0, regs16};
                er = exp_regs(k);
                n_checks++;
                if (gr !== er) begin
                    for (int n = nbr(k) - 1; n >= 0; n--)
                        if (gr[32*n +: 32] !== er[32*n +: 32])
                            $display("FAIL rnd_regs dut%0d it%0d x%0d got %h exp %h", k, it, n, gr[32*n +: 32], er[32*n +: 32]);
                end else n_pass++;
                ge = (k == 0) ? rf_err : rf_err16;
                n_checks++; if (ge !== m_err[k]) $display("FAIL rnd_err dut%0d it%0d got %b exp %b", k, it, ge, m_err[k]); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 32; n++) begin
                m_regs[k][n] = '0;
                m_cnt[k][n]  = '0;
            end
            m_err[k] = 1'b0;
        end
        test_reset();
        test_write_latency();
        test_same_addr();
        test_x0();
        test_claim_sat();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
